// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: samples the PC on start, runs a variable-latency read
// handshake with instruction memory, and latches the word into ir with pc_plus4.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  // The counter only has to reach TIMEOUT-1 before the timeout fires.
  localparam int unsigned CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] CNT_LAST = TLAST[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [31:0]   addr_q;
  logic [31:0]   ir_q;
  logic [31:0]   pc4_q;
  logic          rd_q;
  logic          busy_q;
  logic          done_q;
  logic          fault_q;
  logic [CW-1:0] cnt_q;

  logic [CW-1:0] cnt_d;
  logic [31:0]   pc4_d;
  logic          timeout_hit;
  logic          pc_aligned;

  always_comb begin
    pc_aligned  = (pc[1:0] == 2'b00);
    pc4_d       = addr_q + 32'd4;
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      ir_q    <= RESET_IR;
      pc4_q   <= 32'd0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!pc_aligned) begin
              fault_q <= 1'b1;
            end else begin
              addr_q  <= pc;
              rd_q    <= 1'b1;
              busy_q  <= 1'b1;
              fault_q <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc4_q   <= pc4_d;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            // Abandon the read; ir and pc_plus4 keep the last good fetch.
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          rd_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign ir       = ir_q;
  assign pc_plus4 = pc4_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch results are queued when a
// fetch is issued and compared by a monitor whenever done pulses.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_IR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ir;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        done;
  logic        fault;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done_seen    = 0;
  int   done_expect  = 0;

  instr_fetch_unit #(.TIMEOUT(16), .RESET_IR(RESET_IR)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc        (pc),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .pc_plus4  (pc_plus4),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every done pulse must match the oldest outstanding fetch.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_ir", ir, e.ir);
        check("sb_pc4", pc_plus4, e.pc4);
        check("sb_addr", mem_addr, e.addr);
        $display("[TB] fetch addr=%h ir=%h pc_plus4=%h", mem_addr, ir, pc_plus4);
      end
    end
  end

  // Issue one aligned fetch, insert 'waits' not-ready cycles, then complete it.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] w, input int waits);
    int busy_cycles;
    exp_t e;
    e.addr = a; e.ir = w; e.pc4 = a + 32'd4;
    pc = a;
    start = 1'b1;
    sb.push_back(e);
    done_expect++;
    tick();
    start = 1'b0;
    busy_cycles = 0;
    if (busy === 1'b1) busy_cycles++;
    check("start_rd", {31'd0, mem_rd}, 32'd1);
    check("start_addr", mem_addr, a);
    check("start_fault", {31'd0, fault}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      pc = $urandom;
      tick();
      if (busy === 1'b1) busy_cycles++;
      check("wait_rd", {31'd0, mem_rd}, 32'd1);
      check("wait_addr", mem_addr, a);
      check("wait_done", {31'd0, done}, 32'd0);
    end
    mem_ready = 1'b1;
    mem_rdata = w;
    tick();
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    check("busy_cycles", busy_cycles, waits + 1);
    check("end_done", {31'd0, done}, 32'd1);
    check("end_rd", {31'd0, mem_rd}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
    tick();
    check("idle_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int rd_cycles;
    exp_t e;
    rst = 1'b0; start = 1'b0; pc = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    #1 rst = 1'b1;
    #1;
    check("rst_ir", ir, RESET_IR);
    check("rst_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_pc4", pc_plus4, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Zero-wait fetch
    do_fetch(32'h0000_0100, 32'h2008_0005, 0);

    // Reset asserted mid-WAIT, between clock edges
    pc = 32'h0000_0040;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_rd", {31'd0, mem_rd}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ir", ir, RESET_IR);
    check("arst_pc4", pc_plus4, 32'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    do_fetch(32'h0000_0040, 32'h0000_1111, 1);

    // Wait states with pc wandering during WAIT
    do_fetch(32'h0000_0200, 32'h8C09_0000, 5);

    // Misaligned PC
    pc = 32'h0000_0102;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_rd", {31'd0, mem_rd}, 32'd0);
    check("mis_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    check("mis_rd_later", {31'd0, mem_rd}, 32'd0);
    check("mis_ir", ir, 32'h8C09_0000);
    check("mis_pc4", pc_plus4, 32'h0000_0204);
    do_fetch(32'h0000_0104, 32'hA5A5_0001, 2);

    // Timeout: mem_ready never arrives
    pc = 32'h0000_0300;
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ready = 1'b0;
    rd_cycles = 0;
    for (int i = 0; i < 40 && mem_rd === 1'b1; i++) begin
      rd_cycles++;
      tick();
    end
    check("to_rd_cycles", rd_cycles, 16);
    check("to_rd", {31'd0, mem_rd}, 32'd0);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_ir", ir, 32'hA5A5_0001);
    check("to_pc4", pc_plus4, 32'h0000_0108);
    tick();

    // Address wrap, with start held high through DONE
    pc = 32'hFFFF_FFFC;
    start = 1'b1;
    e.addr = 32'hFFFF_FFFC; e.ir = 32'h1234_5678; e.pc4 = 32'h0000_0000;
    sb.push_back(e);
    done_expect++;
    tick();
    check("wrap_fault", {31'd0, fault}, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    pc = 32'h0000_0500;
    tick();
    mem_ready = 1'b0;
    check("wrap_done", {31'd0, done}, 32'd1);
    tick();
    check("dstart_busy", {31'd0, busy}, 32'd0);
    check("dstart_rd", {31'd0, mem_rd}, 32'd0);
    e.addr = 32'h0000_0500; e.ir = 32'hCAFE_0500; e.pc4 = 32'h0000_0504;
    sb.push_back(e);
    done_expect++;
    tick();
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_addr", mem_addr, 32'h0000_0500);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0500;
    tick();
    mem_ready = 1'b0;
    tick(); tick();
    check("dstart_once", {31'd0, busy}, 32'd0);

    check("done_count", done_seen, done_expect);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
